// File: rtl/rob_nway_pkg.sv
// rob_nway_pkg: shared tags, entry/packet types and index helper for the reorder buffer
package rob_nway_pkg;
  localparam int PHYS_REG_BITS = 6;
  localparam int ROB_SZ_DEFAULT = 32;
  localparam int ROB_WIDTH = 3;
  typedef logic [PHYS_REG_BITS-1:0] phys_tag_t;
  typedef logic [$clog2(ROB_SZ_DEFAULT)-1:0] rob_idx_t;
  typedef struct packed {
    logic valid;
    logic complete;
    logic mispred;
    phys_tag_t dest;
    phys_tag_t told;
  } rob_entry_t;
  typedef struct packed {
    logic valid;
    phys_tag_t dest;
    phys_tag_t told;
  } rob_ret_pkt_t;
  function automatic int wrap_add(int base, int off, int sz);
    return (base + off) % sz;
  endfunction
endpackage

// File: rtl/rob_nway_if.sv
// rob_nway_if: dispatch, completion and retire bundle between rename, execute and freelist
interface rob_nway_if import rob_nway_pkg::*; #(
  parameter int ROB_SZ = ROB_SZ_DEFAULT,
  parameter int WIDTH = ROB_WIDTH,
  parameter int PRB = PHYS_REG_BITS,
  parameter int IDX = $clog2(ROB_SZ)
);
  logic [WIDTH-1:0] disp_valid, disp_accept, cdb_valid, cdb_mispred, retire_valid;
  logic [WIDTH*PRB-1:0] disp_dest, disp_told, retire_dest, retire_told;
  logic [WIDTH*IDX-1:0] disp_idx, cdb_idx;
  logic [$clog2(ROB_SZ+1)-1:0] open_spots;
  logic flush;
  modport master (
    output disp_valid, disp_dest, disp_told, cdb_valid, cdb_idx, cdb_mispred,
    input disp_accept, disp_idx, open_spots, retire_valid, retire_dest, retire_told, flush
  );
  modport slave (
    input disp_valid, disp_dest, disp_told, cdb_valid, cdb_idx, cdb_mispred,
    output disp_accept, disp_idx, open_spots, retire_valid, retire_dest, retire_told, flush
  );
endinterface

// File: rtl/rob_retire_select.sv
// rob_retire_select: length of the retirable prefix from head, cut just after the first mispredict
module rob_retire_select import rob_nway_pkg::*; #(
  parameter int WIDTH = ROB_WIDTH
) (
  input  logic [WIDTH-1:0] valid,
  input  logic [WIDTH-1:0] complete,
  input  logic [WIDTH-1:0] mispred,
  output logic [$clog2(WIDTH+1)-1:0] ret_cnt,
  output logic stop
);
  int n;
  logic go;
  always_comb begin
    n = 0;
    go = 1'b1;
    stop = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (go && valid[k] && complete[k]) begin
        n++;
        stop = stop | mispred[k];
        go = !mispred[k];
      end else go = 1'b0;
    end
    ret_cnt = ($clog2(WIDTH+1))'(n);
  end
endmodule

// File: rtl/rob_nway.sv
// rob_nway: parametrised N-way reorder buffer with index-based completion and mispredict squash
module rob_nway import rob_nway_pkg::*; #(
  parameter int ROB_SZ = ROB_SZ_DEFAULT,
  parameter int WIDTH = ROB_WIDTH,
  parameter int PRB = PHYS_REG_BITS,
  parameter int IDX = $clog2(ROB_SZ)
) (
  input logic clock,
  input logic reset,
  rob_nway_if.slave bus
);
  localparam int OSW = $clog2(ROB_SZ+1);
  localparam int CW = $clog2(WIDTH+1);
  rob_entry_t ent_q [ROB_SZ];
  rob_entry_t ent_d [ROB_SZ];
  rob_ret_pkt_t ret_q [WIDTH];
  rob_ret_pkt_t ret_d [WIDTH];
  logic [IDX-1:0] head_q, head_d, tail_q, tail_d;
  logic [OSW-1:0] count_q, count_d, open_q, open_d;
  logic flush_q, flush_d;
  logic [IDX-1:0] rot_idx [WIDTH];
  logic [1:0] rot_hit [WIDTH];
  logic [WIDTH-1:0] rot_v, rot_c, rot_m;
  logic [CW-1:0] ret_cnt;
  logic stop;
  int acc;
  function automatic logic [1:0] cdb_probe(logic [IDX-1:0] idx, logic [WIDTH-1:0] v,
                                           logic [WIDTH*IDX-1:0] ci, logic [WIDTH-1:0] m);
    cdb_probe = '0;
    for (int j = 0; j < WIDTH; j++)
      if (v[j] && ci[j*IDX +: IDX] == idx) cdb_probe = cdb_probe | {1'b1, m[j]};
  endfunction
  // Acceptance is limited by the registered free count, so retires never free space same-cycle.
  always_comb begin
    acc = 0;
    bus.disp_accept = '0;
    bus.disp_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (bus.disp_valid[i] && acc < int'(open_q)) begin
        bus.disp_accept[i] = 1'b1;
        bus.disp_idx[i*IDX +: IDX] = IDX'(wrap_add(int'(tail_q), acc, ROB_SZ));
        acc++;
      end
  end
  // Head-rotated view with same-cycle CDB bypass folded into complete/mispred.
  always_comb
    for (int k = 0; k < WIDTH; k++) begin
      rot_idx[k] = IDX'(wrap_add(int'(head_q), k, ROB_SZ));
      rot_hit[k] = cdb_probe(rot_idx[k], bus.cdb_valid, bus.cdb_idx, bus.cdb_mispred);
      rot_v[k] = ent_q[rot_idx[k]].valid && k < int'(count_q);
      rot_c[k] = ent_q[rot_idx[k]].complete || rot_hit[k][1];
      rot_m[k] = ent_q[rot_idx[k]].mispred || rot_hit[k][0];
    end
  rob_retire_select #(.WIDTH(WIDTH)) u_sel (
    .valid(rot_v), .complete(rot_c), .mispred(rot_m), .ret_cnt(ret_cnt), .stop(stop)
  );
  always_comb begin
    ent_d = ent_q;
    for (int j = 0; j < WIDTH; j++)
      if (bus.cdb_valid[j] && int'(bus.cdb_idx[j*IDX +: IDX]) < ROB_SZ && ent_q[bus.cdb_idx[j*IDX +: IDX]].valid) begin
        ent_d[bus.cdb_idx[j*IDX +: IDX]].complete = 1'b1;
        ent_d[bus.cdb_idx[j*IDX +: IDX]].mispred = ent_d[bus.cdb_idx[j*IDX +: IDX]].mispred | bus.cdb_mispred[j];
      end
    for (int k = 0; k < WIDTH; k++) begin
      ret_d[k] = k < int'(ret_cnt) ? rob_ret_pkt_t'{1'b1, ent_q[rot_idx[k]].dest, ent_q[rot_idx[k]].told} : '0;
      if (k < int'(ret_cnt)) ent_d[rot_idx[k]].valid = 1'b0;
    end
    for (int i = 0; i < WIDTH; i++)
      if (bus.disp_accept[i])
        ent_d[bus.disp_idx[i*IDX +: IDX]] = rob_entry_t'{1'b1, 1'b0, 1'b0,
          phys_tag_t'(bus.disp_dest[i*PRB +: PRB]), phys_tag_t'(bus.disp_told[i*PRB +: PRB])};
    if (stop) for (int e = 0; e < ROB_SZ; e++) ent_d[e].valid = 1'b0;
    flush_d = stop;
    head_d = IDX'(wrap_add(int'(head_q), int'(ret_cnt), ROB_SZ));
    tail_d = stop ? head_d : IDX'(wrap_add(int'(tail_q), acc, ROB_SZ));
    count_d = stop ? '0 : OSW'(int'(count_q) - int'(ret_cnt) + acc);
    open_d = OSW'(ROB_SZ - int'(count_d));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < ROB_SZ; e++) ent_q[e] <= '0;
      for (int k = 0; k < WIDTH; k++) ret_q[k] <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      open_q <= OSW'(ROB_SZ);
      flush_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      ret_q <= ret_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      open_q <= open_d;
      flush_q <= flush_d;
    end
  end
  assign bus.open_spots = open_q;
  assign bus.flush = flush_q;
  for (genvar g = 0; g < WIDTH; g++) begin : g_ret
    assign bus.retire_valid[g] = ret_q[g].valid;
    assign bus.retire_dest[g*PRB +: PRB] = PRB'(ret_q[g].dest);
    assign bus.retire_told[g*PRB +: PRB] = PRB'(ret_q[g].told);
  end
endmodule

// File: tb/tb_rob_nway.sv
// tb_rob_nway: directed vector checks of rob_nway at ROB_SZ=4 (fill) and ROB_SZ=7 (everything else)
module tb_rob_nway;
  import rob_nway_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clock = ~clock;
  rob_nway_if #(.ROB_SZ(4)) b4 ();
  rob_nway_if #(.ROB_SZ(7)) b7 ();
  rob_nway #(.ROB_SZ(4)) d4 (.clock(clock), .reset(reset), .bus(b4));
  rob_nway #(.ROB_SZ(7)) d7 (.clock(clock), .reset(reset), .bus(b7));
  typedef struct {
    logic [2:0] dv; logic [17:0] told; logic [2:0] cv; logic [8:0] cidx; logic [2:0] cm;
    logic [2:0] acc; logic [8:0] idx; logic [2:0] rv; logic [17:0] rtold; logic fl; logic [2:0] open;
  } vec_t;
  vec_t v [20];
  function automatic logic [17:0] t3(int a, int b, int c);
    return {6'(c), 6'(b), 6'(a)};
  endfunction
  function automatic logic [8:0] i3(int a, int b, int c);
    return {3'(c), 3'(b), 3'(a)};
  endfunction
  function automatic logic [17:0] dst(logic [17:0] t, logic [2:0] m);
    for (int k = 0; k < 3; k++) dst[k*6 +: 6] = m[k] ? t[k*6 +: 6] + 6'd32 : 6'd0;
  endfunction
  function automatic logic [8:0] mask9(logic [2:0] a);
    return {{3{a[2]}}, {3{a[1]}}, {3{a[0]}}};
  endfunction
  function automatic vec_t mk(logic [2:0] dv, logic [17:0] told, logic [2:0] cv, logic [8:0] cidx,
                              logic [2:0] cm, logic [2:0] acc, logic [8:0] idx, logic [2:0] rv,
                              logic [17:0] rtold, logic fl, logic [2:0] open);
    mk = '{dv, told, cv, cidx, cm, acc, idx, rv, rtold, fl, open};
  endfunction
  task automatic chk(string nm, int n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, n, act, exp);
    end
  endtask
  task automatic drive7(logic [2:0] dv, logic [17:0] told, logic [2:0] cv, logic [8:0] cidx, logic [2:0] cm);
    b7.disp_valid = dv;
    b7.disp_told = told;
    b7.disp_dest = dst(told, dv);
    b7.cdb_valid = cv;
    b7.cdb_idx = cidx;
    b7.cdb_mispred = cm;
  endtask
  task automatic chk_ret7(int n, logic [2:0] rv, logic [17:0] rtold, logic fl, logic [2:0] open);
    chk("retire_valid", n, b7.retire_valid, rv);
    chk("retire_told", n, b7.retire_told, rtold);
    chk("retire_dest", n, b7.retire_dest, dst(rtold, rv));
    chk("flush", n, b7.flush, fl);
    chk("open_spots", n, b7.open_spots, open);
  endtask
  initial begin
    v[0]  = mk(3'b111, t3(11,12,13), 3'b000, 0, 3'b000, 3'b111, i3(0,1,2), 3'b000, 0, 0, 4);
    v[1]  = mk(3'b000, 0, 3'b011, i3(1,2,0), 3'b000, 3'b000, 0, 3'b000, 0, 0, 4);
    v[2]  = mk(3'b000, 0, 3'b001, i3(0,0,0), 3'b000, 3'b000, 0, 3'b111, t3(11,12,13), 0, 7);
    v[3]  = mk(3'b111, t3(21,22,23), 3'b000, 0, 3'b000, 3'b111, i3(3,4,5), 3'b000, 0, 0, 4);
    v[4]  = mk(3'b011, t3(24,25,0), 3'b000, 0, 3'b000, 3'b011, i3(6,0,0), 3'b000, 0, 0, 2);
    v[5]  = mk(3'b000, 0, 3'b111, i3(3,4,5), 3'b010, 3'b000, 0, 3'b011, t3(21,22,0), 1, 7);
    v[6]  = mk(3'b000, 0, 3'b001, i3(5,0,0), 3'b000, 3'b000, 0, 3'b000, 0, 0, 7);
    v[7]  = mk(3'b001, t3(1,0,0), 3'b000, 0, 3'b000, 3'b001, i3(5,0,0), 3'b000, 0, 0, 6);
    v[8]  = mk(3'b111, t3(2,3,4), 3'b001, i3(5,0,0), 3'b001, 3'b111, i3(6,0,1), 3'b001, t3(1,0,0), 1, 7);
    v[9]  = mk(3'b000, 0, 3'b111, i3(6,0,1), 3'b000, 3'b000, 0, 3'b000, 0, 0, 7);
    v[10] = mk(3'b111, t3(5,6,7), 3'b000, 0, 3'b000, 3'b111, i3(6,0,1), 3'b000, 0, 0, 4);
    v[11] = mk(3'b111, t3(8,9,10), 3'b000, 0, 3'b000, 3'b111, i3(2,3,4), 3'b000, 0, 0, 1);
    v[12] = mk(3'b111, t3(14,15,16), 3'b001, i3(5,0,0), 3'b000, 3'b001, i3(5,0,0), 3'b000, 0, 0, 0);
    v[13] = mk(3'b111, t3(17,18,19), 3'b011, i3(6,0,0), 3'b000, 3'b000, 0, 3'b011, t3(5,6,0), 0, 2);
    v[14] = mk(3'b000, 0, 3'b111, i3(1,2,3), 3'b000, 3'b000, 0, 3'b111, t3(7,8,9), 0, 5);
    v[15] = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 5);
    v[16] = mk(3'b000, 0, 3'b001, i3(4,0,0), 3'b000, 3'b000, 0, 3'b001, t3(10,0,0), 0, 6);
    v[17] = mk(3'b000, 0, 3'b001, i3(5,0,0), 3'b000, 3'b000, 0, 3'b001, t3(14,0,0), 0, 7);
    v[18] = mk(3'b001, t3(20,0,0), 3'b000, 0, 3'b000, 3'b001, i3(6,0,0), 3'b000, 0, 0, 6);
    v[19] = mk(3'b000, 0, 3'b110, i3(0,6,6), 3'b100, 3'b000, 0, 3'b001, t3(20,0,0), 1, 7);
    b4.disp_valid = '0; b4.disp_dest = '0; b4.disp_told = '0;
    b4.cdb_valid = '0; b4.cdb_idx = '0; b4.cdb_mispred = '0;
    drive7(0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_open4", 0, b4.open_spots, 4);
    chk("rst_accept4", 0, b4.disp_accept, 0);
    chk("rst_rv4", 0, b4.retire_valid, 0);
    chk("rst_flush4", 0, b4.flush, 0);
    chk_ret7(-1, 3'b000, 0, 0, 7);
    @(negedge clock);
    b4.disp_valid = 3'b111;
    b4.disp_told = t3(1,2,3);
    b4.disp_dest = dst(t3(1,2,3), 3'b111);
    #1;
    chk("fill_acc1", 1, b4.disp_accept, 3'b111);
    chk("fill_idx1", 1, b4.disp_idx, {2'd2, 2'd1, 2'd0});
    @(posedge clock); #1;
    chk("fill_open1", 1, b4.open_spots, 1);
    @(negedge clock); #1;
    chk("fill_acc2", 2, b4.disp_accept, 3'b001);
    chk("fill_idx2", 2, b4.disp_idx[1:0], 3);
    @(posedge clock); #1;
    chk("fill_open2", 2, b4.open_spots, 0);
    @(negedge clock); #1;
    chk("fill_acc3", 3, b4.disp_accept, 3'b000);
    b4.disp_valid = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      drive7(v[n].dv, v[n].told, v[n].cv, v[n].cidx, v[n].cm);
      #1;
      chk("disp_accept", n, b7.disp_accept, v[n].acc);
      if (v[n].acc != 0) chk("disp_idx", n, b7.disp_idx & mask9(v[n].acc), v[n].idx & mask9(v[n].acc));
      @(posedge clock); #1;
      chk_ret7(n, v[n].rv, v[n].rtold, v[n].fl, v[n].open);
    end
    @(negedge clock);
    drive7(3'b101, t3(27,0,28), 0, 0, 0);
    #1;
    chk("gap_accept", 100, b7.disp_accept, 3'b101);
    chk("gap_idx0", 100, b7.disp_idx[2:0], 0);
    chk("gap_idx2", 100, b7.disp_idx[8:6], 1);
    @(posedge clock); #1;
    chk_ret7(100, 3'b000, 0, 0, 5);
    @(negedge clock);
    drive7(0, 0, 3'b011, i3(0,1,0), 0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_ret7(101, 3'b000, 0, 0, 7);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk_ret7(102, 3'b000, 0, 0, 7);
    @(posedge clock); #1;
    chk_ret7(103, 3'b000, 0, 0, 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
